// File: rtl/picorisc_pkg.sv
// Shared picoRISC types and default widths.
package picorisc_pkg;

  localparam int unsigned P_ADDR = 6;
  localparam int unsigned I_MSB  = 24;

  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: async reset, load has priority over increment, else hold.
module pc_reg
  import picorisc_pkg::*;
#(
  parameter int unsigned W = P_ADDR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc
);

  // PC update; increment wraps naturally in W bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures instructions into IR,
// handles start/halt/stall and branch redirect with a one-bubble flush.
module fetch_unit
  import picorisc_pkg::*;
#(
  parameter int unsigned p = P_ADDR,
  parameter int unsigned i = I_MSB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         halt,
  input  logic         stall,
  input  logic         branch_en,
  input  logic [p-1:0] branch_target,
  input  logic [i:0]   instr_code,
  output logic [p-1:0] addr,
  output logic [i:0]   ir,
  output logic [p-1:0] ir_pc,
  output logic         ir_valid,
  output logic         running
);

  fetch_state_t state, state_nxt;
  logic [p-1:0] pc;
  logic [i:0]   ir_nxt;
  logic [p-1:0] ir_pc_nxt;
  logic         ir_valid_nxt;
  logic         pc_load_c;
  logic         pc_inc_c;

  pc_reg #(.W(p)) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load_c),
    .inc      (pc_inc_c),
    .load_val (branch_target),
    .pc       (pc)
  );

  // Memory is combinational-read, so the address is simply the PC.
  assign addr = pc;

  // State, IR and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_valid <= ir_valid_nxt;
      running  <= (state_nxt == RUN);
    end
  end

  // Next state and fetch control; priority halt > branch > stall > fetch.
  always_comb begin
    state_nxt    = state;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_valid_nxt = 1'b0;
    pc_load_c    = 1'b0;
    pc_inc_c     = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (halt) begin
          state_nxt = HALT;
        end else if (branch_en) begin
          pc_load_c = 1'b1;
        end else if (stall) begin
          ir_valid_nxt = ir_valid;
        end else begin
          ir_nxt       = instr_code;
          ir_pc_nxt    = pc;
          ir_valid_nxt = 1'b1;
          pc_inc_c     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
